fp_add_pipe: RTL

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with valid/ready flow control, round-to-nearest-even, full special-value handling and exception flags. It succeeds the combinational bf16 adder. Format width comes from `E`/`M`, so bf16, fp16 and fp32 are all supported. It sits between operand-issue logic and the result writeback and accepts one operation per cycle.

---
 rtl/fp_add_pipe.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage pipelined floating-point adder/subtractor.
//   Format is {sign, E-bit exponent, M-bit mantissa}. Rounding is
//   round-to-nearest-even. NaN, inf and signed zero are handled, and the
//   invalid/overflow/underflow/inexact flags are produced.
//   Stage 1 classifies and orders the operands, stage 2 aligns, adds and
//   counts leading zeros, and stage 3 normalizes, rounds and packs.
//   All stages advance together when the output slot is empty or being taken.
// Configuration macro: FP_ADD_SUBNORMAL_EN (defined: gradual underflow;
//   undefined: subnormal inputs read as zero and tiny results flush to zero).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid_i / in_ready_o     operand handshake
//   sa_i, ea_i, ma_i            operand a
//   sb_i, eb_i, mb_i            operand b
//   sub_i                       1: a - b, 0: a + b
//   out_valid_o / out_ready_i   result handshake
//   s_o, e_o, m_o               result
//   nv_o, of_o, uf_o, nx_o      exception flags, qualified by out_valid_o
module fp_add_pipe #(
  parameter int unsigned E = 8,
  parameter int unsigned M = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         sa_i,
  input  logic [E-1:0] ea_i,
  input  logic [M-1:0] ma_i,
  input  logic         sb_i,
  input  logic [E-1:0] eb_i,
  input  logic [M-1:0] mb_i,
  input  logic         sub_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         s_o,
  output logic [E-1:0] e_o,
  output logic [M-1:0] m_o,
  output logic         nv_o,
  output logic         of_o,
  output logic         uf_o,
  output logic         nx_o
);

  localparam int unsigned EW = E + 2;   // signed exponent / shift width
  localparam int unsigned F  = M + 4;   // hidden, mantissa, guard, round, sticky
  localparam logic signed [EW-1:0] EMAX = EW'((1 << E) - 1);

  logic adv;

  // ---------------- stage 1: classify and swap ----------------
  logic         sbe, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, swap;
  logic [M:0]   a_sig, b_sig;
  logic [E-1:0] a_exp, b_exp;
  logic [E+M-1:0] a_mag, b_mag;
  logic         s1_valid_d, s1_sign_d, s1_sub_d, s1_nan_d, s1_nv_d, s1_inf_d, s1_infs_d, s1_zs_d;
  logic [E-1:0] s1_ex_d, s1_d_d;
  logic [M:0]   s1_sigx_d, s1_sigy_d;

  always_comb begin
    sbe    = sb_i ^ sub_i;
    a_nan  = (ea_i == '1) && (ma_i != '0);
    b_nan  = (eb_i == '1) && (mb_i != '0);
    a_inf  = (ea_i == '1) && (ma_i == '0);
    b_inf  = (eb_i == '1) && (mb_i == '0);
    a_snan = a_nan & ~ma_i[M-1];
    b_snan = b_nan & ~mb_i[M-1];
`ifdef FP_ADD_SUBNORMAL_EN
    a_sig = {(ea_i != '0), ma_i};
    b_sig = {(eb_i != '0), mb_i};
    a_exp = (ea_i == '0) ? E'(1) : ea_i;
    b_exp = (eb_i == '0) ? E'(1) : eb_i;
    a_mag = {ea_i, ma_i};
    b_mag = {eb_i, mb_i};
`else
    a_sig = (ea_i == '0) ? '0 : {1'b1, ma_i};
    b_sig = (eb_i == '0) ? '0 : {1'b1, mb_i};
    a_exp = ea_i;
    b_exp = eb_i;
    a_mag = (ea_i == '0) ? '0 : {ea_i, ma_i};
    b_mag = (eb_i == '0) ? '0 : {eb_i, mb_i};
`endif
    swap       = b_mag > a_mag;
    s1_valid_d = in_valid_i;
    s1_sign_d  = swap ? sbe : sa_i;
    s1_ex_d    = swap ? b_exp : a_exp;
    s1_d_d     = swap ? (b_exp - a_exp) : (a_exp - b_exp);
    s1_sigx_d  = swap ? b_sig : a_sig;
    s1_sigy_d  = swap ? a_sig : b_sig;
    s1_sub_d   = sa_i ^ sbe;
    s1_nan_d   = a_nan | b_nan | (a_inf & b_inf & (sa_i ^ sbe));
    s1_nv_d    = a_snan | b_snan | (a_inf & b_inf & (sa_i ^ sbe));
    s1_inf_d   = a_inf | b_inf;
    s1_infs_d  = a_inf ? sa_i : sbe;
    s1_zs_d    = sa_i & sbe;
  end

  logic         s1_valid_q, s1_sign_q, s1_sub_q, s1_nan_q, s1_nv_q, s1_inf_q, s1_infs_q, s1_zs_q;
  logic [E-1:0] s1_ex_q, s1_d_q;
  logic [M:0]   s1_sigx_q, s1_sigy_q;

  // ---------------- stage 2: align, add, leading-zero count ----------------
  logic [EW-1:0] d_ext, al_sh;
  logic [F-1:0]  x_ext, y_ext, y_shr, y_lost, y_al;
  logic [F:0]    s2_sum_d;
  logic [EW-1:0] s2_lzc_d;

  always_comb begin
    d_ext  = {2'b00, s1_d_q};
    al_sh  = (d_ext > EW'(M + 3)) ? EW'(M + 3) : d_ext;
    x_ext  = {s1_sigx_q, 3'b000};
    y_ext  = {s1_sigy_q, 3'b000};
    y_shr  = y_ext >> al_sh;
    y_lost = y_ext & ~({F{1'b1}} << al_sh);
    y_al   = {y_shr[F-1:1], y_shr[0] | (|y_lost)};
    s2_sum_d = s1_sub_q ? ({1'b0, x_ext} - {1'b0, y_al}) : ({1'b0, x_ext} + {1'b0, y_al});
    s2_lzc_d = EW'(F);
    for (int unsigned i = 0; i < F; i++) begin
      if (s2_sum_d[i]) s2_lzc_d = EW'(F - 1 - i);
    end
  end

  logic          s2_valid_q, s2_sign_q, s2_nan_q, s2_nv_q, s2_inf_q, s2_infs_q, s2_zs_q;
  logic [E-1:0]  s2_ex_q;
  logic [F:0]    s2_sum_q;
  logic [EW-1:0] s2_lzc_q;

  // ---------------- stage 3: normalize, round, pack ----------------
  logic [EW-1:0]        ex_ext, nsh;
  logic signed [EW-1:0] expn, exp_r;
  logic [F-1:0]         norm;
  logic [M:0]           sig, sig_f;
  logic [M+1:0]         sig_r;
  logic                 g, r, st, rnd, inexact;
  logic                 res_s, res_nv, res_of, res_uf, res_nx;
  logic [E-1:0]         res_e;
  logic [M-1:0]         res_m;

  always_comb begin
    ex_ext = {2'b00, s2_ex_q};
    nsh    = s2_lzc_q;
    if (s2_sum_q[F]) begin
      norm = {s2_sum_q[F:2], |s2_sum_q[1:0]};
      expn = $signed(ex_ext + EW'(1));
    end else begin
`ifdef FP_ADD_SUBNORMAL_EN
      // Cancellation below the normal range is exact, so capping the left
      // shift at ex-1 yields the denormalized significand directly.
      if (s2_lzc_q >= ex_ext) nsh = ex_ext - EW'(1);
`endif
      norm = s2_sum_q[F-1:0] << nsh;
      expn = $signed(ex_ext - nsh);
    end
    sig     = norm[F-1:3];
    g       = norm[2];
    r       = norm[1];
    st      = norm[0];
    inexact = g | r | st;
    rnd     = g & (r | st | sig[0]);
    sig_r   = {1'b0, sig} + {{(M + 1){1'b0}}, rnd};
    if (sig_r[M+1]) begin
      sig_f = sig_r[M+1:1];
      exp_r = expn + EW'(1);
    end else begin
      sig_f = sig_r[M:0];
      exp_r = expn;
    end

    res_s  = s2_sign_q;
    res_e  = sig_f[M] ? exp_r[E-1:0] : '0;
    res_m  = sig_f[M-1:0];
    res_nv = 1'b0;
    res_of = 1'b0;
    res_uf = 1'b0;
    res_nx = inexact;
`ifdef FP_ADD_SUBNORMAL_EN
    res_uf = ~norm[F-1] & inexact;
`endif
    if (s2_nan_q) begin
      res_s  = 1'b0;
      res_e  = '1;
      res_m  = {1'b1, {(M - 1){1'b0}}};
      res_nv = s2_nv_q;
      res_uf = 1'b0;
      res_nx = 1'b0;
    end else if (s2_inf_q) begin
      res_s  = s2_infs_q;
      res_e  = '1;
      res_m  = '0;
      res_uf = 1'b0;
      res_nx = 1'b0;
    end else if (s2_sum_q == '0) begin
      res_s  = s2_zs_q;
      res_e  = '0;
      res_m  = '0;
      res_uf = 1'b0;
      res_nx = 1'b0;
    end else if (exp_r >= EMAX) begin
      res_e  = '1;
      res_m  = '0;
      res_of = 1'b1;
      res_uf = 1'b0;
      res_nx = 1'b1;
`ifndef FP_ADD_SUBNORMAL_EN
    end else if (exp_r[EW-1] || exp_r == '0) begin
      res_e  = '0;
      res_m  = '0;
      res_uf = 1'b1;
      res_nx = 1'b1;
`endif
    end
  end

  logic         out_valid_q, out_s_q, out_nv_q, out_of_q, out_uf_q, out_nx_q;
  logic [E-1:0] out_e_q;
  logic [M-1:0] out_m_q;

  assign adv        = ~out_valid_q | out_ready_i;
  assign in_ready_o = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0; s1_sign_q <= 1'b0; s1_sub_q <= 1'b0; s1_nan_q <= 1'b0;
      s1_nv_q <= 1'b0; s1_inf_q <= 1'b0; s1_infs_q <= 1'b0; s1_zs_q <= 1'b0;
      s1_ex_q <= '0; s1_d_q <= '0; s1_sigx_q <= '0; s1_sigy_q <= '0;
      s2_valid_q <= 1'b0; s2_sign_q <= 1'b0; s2_nan_q <= 1'b0; s2_nv_q <= 1'b0;
      s2_inf_q <= 1'b0; s2_infs_q <= 1'b0; s2_zs_q <= 1'b0;
      s2_ex_q <= '0; s2_sum_q <= '0; s2_lzc_q <= '0;
      out_valid_q <= 1'b0; out_s_q <= 1'b0; out_e_q <= '0; out_m_q <= '0;
      out_nv_q <= 1'b0; out_of_q <= 1'b0; out_uf_q <= 1'b0; out_nx_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= s1_valid_d; s1_sign_q <= s1_sign_d; s1_sub_q <= s1_sub_d;
      s1_nan_q <= s1_nan_d; s1_nv_q <= s1_nv_d; s1_inf_q <= s1_inf_d;
      s1_infs_q <= s1_infs_d; s1_zs_q <= s1_zs_d;
      s1_ex_q <= s1_ex_d; s1_d_q <= s1_d_d; s1_sigx_q <= s1_sigx_d; s1_sigy_q <= s1_sigy_d;
      s2_valid_q <= s1_valid_q; s2_sign_q <= s1_sign_q; s2_nan_q <= s1_nan_q;
      s2_nv_q <= s1_nv_q; s2_inf_q <= s1_inf_q; s2_infs_q <= s1_infs_q; s2_zs_q <= s1_zs_q;
      s2_ex_q <= s1_ex_q; s2_sum_q <= s2_sum_d; s2_lzc_q <= s2_lzc_d;
      out_valid_q <= s2_valid_q; out_s_q <= res_s; out_e_q <= res_e; out_m_q <= res_m;
      out_nv_q <= res_nv; out_of_q <= res_of; out_uf_q <= res_uf; out_nx_q <= res_nx;
    end
  end

  assign out_valid_o = out_valid_q;
  assign s_o  = out_s_q;
  assign e_o  = out_e_q;
  assign m_o  = out_m_q;
  assign nv_o = out_nv_q;
  assign of_o = out_of_q;
  assign uf_o = out_uf_q;
  assign nx_o = out_nx_q;

endmodule
